// File: rtl/register_addr_bank.sv
// Indexed bank of address registers with stepped inc/dec, sticky wrap flags
// and a shadow copy for one-cycle save, restore and swap.
module register_addr_bank #(
    parameter int               COUNT       = 5,
    parameter int               WIDTH       = 16,
    parameter int               STEP_W      = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SEL_W       = $clog2(COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  addr_sel,
    input  logic              assert_addr,
    input  logic [SEL_W-1:0]  xfer_sel,
    input  logic              assert_xfer,
    input  logic [SEL_W-1:0]  load_sel,
    input  logic              load_xfer,
    input  logic [WIDTH-1:0]  xfer_in,
    input  logic [SEL_W-1:0]  step_sel,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic              save,
    input  logic              restore,
    input  logic              clear_wrap,
    output logic [WIDTH-1:0]  addr_out,
    output logic              addr_en,
    output logic [WIDTH-1:0]  xfer_out,
    output logic              xfer_en,
    output logic [COUNT-1:0]  wrap
);

    logic [WIDTH-1:0]  live_q   [COUNT];
    logic [WIDTH-1:0]  live_d   [COUNT];
    logic [WIDTH-1:0]  shadow_q [COUNT];
    logic [WIDTH-1:0]  shadow_d [COUNT];
    logic [COUNT-1:0]  wrap_q;
    logic [COUNT-1:0]  wrap_d;
    logic [STEP_W-1:0] step_eff;
    logic [WIDTH:0]    step_ext;
    logic              do_step;

    // Out-of-range selectors never match any index, so they drive nothing.
    always_comb begin
        addr_en  = 1'b0;
        addr_out = '0;
        xfer_en  = 1'b0;
        xfer_out = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (assert_addr && addr_sel == SEL_W'(i)) begin
                addr_en  = 1'b1;
                addr_out = live_q[i];
            end
            if (assert_xfer && xfer_sel == SEL_W'(i)) begin
                xfer_en  = 1'b1;
                xfer_out = live_q[i];
            end
        end
    end

    assign step_eff = (step == '0) ? STEP_W'(1) : step;
    assign step_ext = (WIDTH+1)'(step_eff);
    assign do_step  = inc ^ dec;

    // Extra top bit of the step result captures carry-out or borrow.
    always_comb begin
        logic [WIDTH:0] res;
        res      = '0;
        live_d   = live_q;
        shadow_d = shadow_q;
        wrap_d   = clear_wrap ? '0 : wrap_q;
        for (int i = 0; i < COUNT; i++) begin
            res = '0;
            if (restore) begin
                live_d[i] = shadow_q[i];
            end else if (load_xfer && load_sel == SEL_W'(i)) begin
                live_d[i] = xfer_in;
            end else if (do_step && step_sel == SEL_W'(i)) begin
                res = inc ? {1'b0, live_q[i]} + step_ext
                          : {1'b0, live_q[i]} - step_ext;
                live_d[i] = res[WIDTH-1:0];
                if (res[WIDTH]) wrap_d[i] = 1'b1;
            end
            if (save) shadow_d[i] = live_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COUNT; i++) begin
                live_q[i]   <= RESET_VALUE;
                shadow_q[i] <= '0;
            end
            wrap_q <= '0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
            wrap_q   <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: doc/register_addr_bank.md
Name: register_addr_bank

Overview:
Parametrised bank of COUNT 16-bit-class address registers. It is the next generation of the per-register pcra0/pcra1/sp/si/di instances. Registers are index-selected rather than driven by per-register strobes. Each register has a variable-step inc/dec, sticky wrap flags, and a one-cycle shadow save/restore/swap for context switching. It drives the addr and xfer buses through the standard out/en bus-source interface and loads from the xfer bus.

Parameters:
COUNT, 5, number of address registers (index 0..COUNT-1)
WIDTH, 16, register and bus width in bits
STEP_W, 4, width of the step input
RESET_VALUE, 0, value loaded into every live register on reset
SEL_W, $clog2(COUNT), selector width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
addr_sel  in  SEL_W  register driven onto addr bus
assert_addr  in  1  request addr bus drive
xfer_sel  in  SEL_W  register driven onto xfer bus
assert_xfer  in  1  request xfer bus drive
load_sel  in  SEL_W  register loaded from xfer_in
load_xfer  in  1  load strobe
xfer_in  in  WIDTH  xfer bus value
step_sel  in  SEL_W  register targeted by inc/dec
inc  in  1  add step
dec  in  1  subtract step
step  in  STEP_W  step magnitude, zero-extended; 0 treated as 1
save  in  1  copy all live registers to shadow
restore  in  1  copy shadow to live registers
clear_wrap  in  1  clear all wrap flags
addr_out  out  WIDTH  addr bus source value
addr_en  out  1  addr bus source enable
xfer_out  out  WIDTH  xfer bus source value
xfer_en  out  1  xfer bus source enable
wrap  out  COUNT  sticky per-register wrap flags

Behaviour:
- Reset (sync, highest priority): all live regs <= RESET_VALUE; all shadow regs <= 0; wrap <= 0.
- Bus drive is combinational, zero latency. addr_en = assert_addr & (addr_sel < COUNT); addr_out = addr_en ? reg[addr_sel] : 0. xfer_en and xfer_out follow the same rule with xfer_sel. The two ports are independent and may select the same register.
- Live register next-value priority, per register: reset > restore > load > inc/dec > hold.
- Load: when load_xfer & (load_sel < COUNT), reg[load_sel] <= xfer_in. This overrides inc/dec on the same register in the same cycle. Inc/dec on other registers proceed.
- Inc/dec: effective step s = (step==0) ? 1 : step.
  - inc only: reg <= (reg + s) mod 2^WIDTH.
  - dec only: reg <= (reg - s) mod 2^WIDTH.
  - inc & dec together: hold, no wrap.
  - step_sel >= COUNT: ignored.
- Wrap: wrap[i] <= 1 when an inc on reg i carries out of WIDTH bits, or a dec borrows. The flag stays set until reset or clear_wrap. If clear_wrap coincides with a new wrap event, set wins.
- Wrap on a register is never set by load or restore.
- Save only: shadow[i] <= reg[i] (pre-update value) for all i. Live regs update normally in the same cycle.
- Restore only: reg[i] <= shadow[i] for all i. Load and inc/dec that cycle are discarded. Shadow holds.
- Save & restore together: atomic swap, live <-> shadow.
- A selector >= COUNT (only possible when COUNT is not a power of two) never drives, loads or steps.
- Reset asserted mid-sequence (for example between save and restore) loses the shadow contents. This is required behaviour.
- Bus contention with other sources is resolved by the shared bus module and is not detected here.

Test Plan:
- Reset -> all regs 0; wrap=0; assert_addr=1, addr_sel=2 -> addr_en=1, addr_out=0x0000. assert_addr=0 -> addr_en=0, addr_out=0.
- load_xfer, load_sel=3, xfer_in=0x1234; next cycle assert_xfer, xfer_sel=3 -> xfer_out=0x1234, xfer_en=1. In the same cycle, addr_sel=3 on addr bus -> addr_out=0x1234.
- reg1=0xFFFE, inc, step=3 -> reg1=0x0001, wrap[1]=1. Then dec, step=0 on reg1 -> 0x0000, wrap[1] stays 1. clear_wrap -> wrap=0.
- reg0=0x0000, dec, step=1 -> reg0=0xFFFF, wrap[0]=1. Same-cycle load_sel=0 with xfer_in=0x00AA and inc on reg0 -> reg0=0x00AA, no wrap change.
- Regs 0..4 = 0x10..0x14; save; load all to 0; restore -> regs 0x10..0x14. save & restore same cycle with live = 0x20.. -> live=0x10..0x14, shadow=0x20..0x24.
- COUNT=5: addr_sel=6 with assert_addr -> addr_en=0. load_sel=7 with load_xfer -> no register changes. inc and dec both set on reg2=0x0050 -> stays 0x0050, wrap unchanged.
